// File: rtl/track_sequencer.sv
// Track selector for the music player. Holds the index of the track that is
// playing and moves it on next/prev button releases or when a song ends.
// Play modes: wrap, linear, repeat-one and shuffle. Shuffle draws its index
// from a free-running 8-bit LFSR. select and start are registered, so start
// is high in the same cycle that a new select value first appears.
module track_sequencer #(
  parameter int          N_TRACKS  = 4,
  parameter int          SEL_W     = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next,
  input  logic             prev,
  input  logic             song_end,
  input  logic [1:0]       mode,
  output logic [SEL_W-1:0] select,
  output logic             start,
  output logic             finished
);

  localparam logic [1:0] M_WRAP   = 2'b00;
  localparam logic [1:0] M_LINEAR = 2'b01;
  localparam logic [1:0] M_REPEAT = 2'b10;
  localparam logic [1:0] M_SHUF   = 2'b11;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_TRACKS - 1);

  // Modulo width: wide enough for both the LFSR and the track index.
  localparam int MW = (SEL_W > 8) ? SEL_W : 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD_N  = 3'd1,
    HOLD_P  = 3'd2,
    ADVANCE = 3'd3,
    RETREAT = 3'd4,
    REPLAY  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_select;
  logic [SEL_W-1:0] w_select_nxt;
  logic             r_start;
  logic             w_start_nxt;
  logic             r_finished;
  logic             w_finished_nxt;
  // Remembers that ADVANCE was reached from song_end, not from a button.
  // Only the linear-mode "parked" case needs this distinction.
  logic             r_from_end;
  logic             w_from_end_nxt;
  logic [7:0]       r_lfsr;
  logic             w_lfsr_fb;

  logic [MW-1:0]    w_lfsr_ext;
  logic [MW-1:0]    w_mod;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_shuf;
  logic [SEL_W-1:0] w_inc;
  logic [SEL_W-1:0] w_dec;

  assign select   = r_select;
  assign start    = r_start;
  assign finished = r_finished;

  // Fibonacci taps 8,6,5,4 (maximal length), so a nonzero seed never reaches 0.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Shuffle pick: LFSR modulo track count, bumped by one (wrapping) if it
  // would replay the current track.
  assign w_lfsr_ext = MW'(r_lfsr);
  assign w_mod      = w_lfsr_ext % MW'(N_TRACKS);
  assign w_idx      = SEL_W'(w_mod);
  assign w_inc      = (r_select == LAST) ? '0 : r_select + 1'b1;
  assign w_dec      = (r_select == '0)   ? LAST : r_select - 1'b1;
  assign w_shuf     = (w_idx != r_select) ? w_idx :
                      (w_idx == LAST)     ? '0    : w_idx + 1'b1;

  // LFSR shifts on every clock, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: song_end beats prev beats next in IDLE; moves happen on
  // button release.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (song_end)  w_state_nxt = (mode == M_REPEAT) ? REPLAY : ADVANCE;
        else if (prev) w_state_nxt = HOLD_P;
        else if (next) w_state_nxt = HOLD_N;
      end
      HOLD_N:  if (!next) w_state_nxt = ADVANCE;
      HOLD_P:  if (!prev) w_state_nxt = RETREAT;
      ADVANCE: w_state_nxt = IDLE;
      RETREAT: w_state_nxt = IDLE;
      REPLAY:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for select/start/finished; mode is read in the
  // cycle the move is applied.
  always_comb begin
    w_select_nxt   = r_select;
    w_start_nxt    = r_start;
    w_finished_nxt = r_finished;
    w_from_end_nxt = r_from_end;
    case (r_state)
      IDLE: begin
        w_start_nxt    = 1'b0;
        w_from_end_nxt = song_end;
      end
      ADVANCE: begin
        case (mode)
          M_LINEAR: begin
            if (r_select == LAST) begin
              // Parked on the last track: no restart, flag end of playlist
              // only when the song actually ran out.
              w_start_nxt = 1'b0;
              if (r_from_end) w_finished_nxt = 1'b1;
            end else begin
              w_select_nxt = r_select + 1'b1;
              w_start_nxt  = 1'b1;
            end
          end
          M_SHUF: begin
            w_select_nxt = w_shuf;
            w_start_nxt  = 1'b1;
          end
          default: begin
            w_select_nxt = w_inc;
            w_start_nxt  = 1'b1;
          end
        endcase
      end
      RETREAT: begin
        // Linear mode on track 0 restarts the track rather than wrapping.
        w_select_nxt = ((mode == M_LINEAR) && (r_select == '0)) ? '0 : w_dec;
        w_start_nxt  = 1'b1;
      end
      REPLAY: begin
        w_start_nxt = 1'b1;
      end
      default: ;
    endcase
    // Any (re)start clears the end-of-playlist flag.
    if (w_start_nxt) w_finished_nxt = 1'b0;
  end

  // Output registers; start is high through reset so the note sequencer
  // begins track 0 as soon as reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_select   <= '0;
      r_start    <= 1'b1;
      r_finished <= 1'b0;
      r_from_end <= 1'b0;
    end else begin
      r_select   <= w_select_nxt;
      r_start    <= w_start_nxt;
      r_finished <= w_finished_nxt;
      r_from_end <= w_from_end_nxt;
    end
  end

endmodule

// File: tb/tb_track_sequencer.sv
// Directed bench for track_sequencer (N_TRACKS=4). Inputs change and outputs
// are sampled 1ns after each rising edge; a small LFSR model predicts shuffle.
module tb_track_sequencer;

  logic       clk;
  logic       reset;
  logic       b_next;
  logic       b_prev;
  logic       b_end;
  logic [1:0] b_mode;
  logic [1:0] select;
  logic       start;
  logic       finished;

  int checks;
  int errors;

  logic [7:0] m_lfsr;

  track_sequencer #(.N_TRACKS(4), .SEL_W(2), .LFSR_SEED(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .next     (b_next),
    .prev     (b_prev),
    .song_end (b_end),
    .mode     (b_mode),
    .select   (select),
    .start    (start),
    .finished (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4, shifting every clock.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press and release a button; returns just after the edge that applies the move.
  task automatic press_next();
    b_next = 1'b1; tick();
    b_next = 1'b0; tick();
    tick();
  endtask

  task automatic press_prev();
    b_prev = 1'b1; tick();
    b_prev = 1'b0; tick();
    tick();
  endtask

  task automatic pulse_end();
    b_end = 1'b1; tick();
    b_end = 1'b0; tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL reset_select got %0d want 0", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL reset_start got %0b want 1", start); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got %0b want 0", finished); end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_after_release got %0b want 1", start); end
    tick();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_first_idle got %0b want 0", start); end
  endtask

  task automatic test_wrap_next();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
    b_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      b_next = 1'b1; tick();
      b_next = 1'b0; tick();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL wrap_hold_start[%0d] got %0b want 0", i, start); end
      tick();
      checks++; if (select !== exp_sel[i]) begin errors++; $display("FAIL wrap_next_sel[%0d] got %0d want %0d", i, select, exp_sel[i]); end
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL wrap_next_start[%0d] got %0b want 1", i, start); end
      tick();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL wrap_next_pulse[%0d] got %0b want 0", i, start); end
    end
  endtask

  task automatic test_wrap_prev_end();
    b_mode = 2'b00;
    press_prev();
    checks++; if (select !== 2'd3) begin errors++; $display("FAIL wrap_prev_sel got %0d want 3", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL wrap_prev_start got %0b want 1", start); end
    tick();
    pulse_end();
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL wrap_end_sel got %0d want 0", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL wrap_end_start got %0b want 1", start); end
    tick();
  endtask

  task automatic test_linear();
    b_mode = 2'b01;
    for (int i = 0; i < 3; i++) begin press_next(); tick(); end
    checks++; if (select !== 2'd3) begin errors++; $display("FAIL lin_setup_sel got %0d want 3", select); end
    pulse_end();
    checks++; if (select !== 2'd3) begin errors++; $display("FAIL lin_end_sel got %0d want 3", select); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL lin_end_start got %0b want 0", start); end
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL lin_end_finished got %0b want 1", finished); end
    tick();
    // next on the last track: parked, no restart, flag kept
    press_next();
    checks++; if (select !== 2'd3) begin errors++; $display("FAIL lin_next_last_sel got %0d want 3", select); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL lin_next_last_start got %0b want 0", start); end
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL lin_next_last_fin got %0b want 1", finished); end
    tick();
    press_prev();
    checks++; if (select !== 2'd2) begin errors++; $display("FAIL lin_prev_sel got %0d want 2", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL lin_prev_start got %0b want 1", start); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL lin_prev_finished got %0b want 0", finished); end
    tick();
  endtask

  task automatic test_repeat();
    b_mode = 2'b10;
    pulse_end();
    checks++; if (select !== 2'd2) begin errors++; $display("FAIL rep_end_sel got %0d want 2", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL rep_end_start got %0b want 1", start); end
    tick();
    press_next();
    checks++; if (select !== 2'd3) begin errors++; $display("FAIL rep_next_sel got %0d want 3", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL rep_next_start got %0b want 1", start); end
    tick();
  endtask

  task automatic test_shuffle();
    logic [1:0] prev_sel;
    logic [1:0] exp;
    logic [3:0] seen;
    b_mode = 2'b11;
    seen = 4'b0;
    for (int i = 0; i < 50; i++) begin
      prev_sel = select;
      b_end = 1'b1; tick();
      b_end = 1'b0;
      // m_lfsr now holds the value the ADVANCE cycle will use
      exp = 2'(m_lfsr % 8'd4);
      if (exp == prev_sel) exp = exp + 2'd1;
      tick();
      checks++; if (select !== exp) begin errors++; $display("FAIL shuf_sel[%0d] got %0d want %0d", i, select, exp); end
      checks++; if (select === prev_sel) begin errors++; $display("FAIL shuf_repeat[%0d] got %0d want not %0d", i, select, prev_sel); end
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL shuf_start[%0d] got %0b want 1", i, start); end
      if (!$isunknown(select)) seen[select] = 1'b1;
      tick();
    end
    checks++; if (seen !== 4'hF) begin errors++; $display("FAIL shuf_visited got %b want 1111", seen); end
  endtask

  task automatic test_reset_mid_hold();
    b_mode = 2'b00;
    b_next = 1'b1; tick();   // now in HOLD_N
    reset = 1'b1; #1;
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL rst_hold_sel got %0d want 0", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL rst_hold_start got %0b want 1", start); end
    tick();
    b_next = 1'b0; tick();
    reset = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (select !== 2'd0 || start !== 1'b0) begin errors++; $display("FAIL rst_no_advance[%0d] got sel %0d start %0b want sel 0 start 0", i, select, start); end
      tick();
    end
  endtask

  task automatic test_linear_prev0();
    b_mode = 2'b01;
    press_prev();
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL lin_prev0_sel got %0d want 0", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL lin_prev0_start got %0b want 1", start); end
    tick();
  endtask

  task automatic test_held_through_reset();
    b_mode = 2'b00;
    b_next = 1'b1;
    reset = 1'b1; tick();
    reset = 1'b0; tick();   // IDLE sees next held: new press
    b_next = 1'b0; tick();
    tick();
    checks++; if (select !== 2'd1) begin errors++; $display("FAIL held_reset_sel got %0d want 1", select); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL held_reset_start got %0b want 1", start); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    b_next = 1'b0;
    b_prev = 1'b0;
    b_end  = 1'b0;
    b_mode = 2'b00;
    test_reset();
    test_wrap_next();
    test_wrap_prev_end();
    test_linear();
    test_repeat();
    test_shuffle();
    test_reset_mid_hold();
    test_linear_prev0();
    test_held_through_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
